// File: rtl/run3_pkg.sv
// Shared types and defaults for the run-of-three nibble scanner.
package run3_pkg;

    localparam int NIBBLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/run3_nib.sv
// Flags a nibble that holds three or more equal adjacent bits.
module run3_nib (
    input  logic [3:0] nib,
    output logic       hit
);

    // A 4-bit run satisfies both terms, so it still yields a single hit.
    assign hit = ((nib[0] == nib[1]) && (nib[1] == nib[2])) ||
                 ((nib[1] == nib[2]) && (nib[2] == nib[3]));

endmodule

// File: rtl/run3_scan_ctrl.sv
// Accepts a word, scans one nibble per cycle for runs of three equal bits,
// then holds the hit count and the first hit index until the consumer takes them.
module run3_scan_ctrl
    import run3_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [4*NIBBLES-1:0]         in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(NIBBLES+1)-1:0] hit_cnt,
    output logic                         hit_any,
    output logic [$clog2(NIBBLES)-1:0]   first_idx,
    output logic                         busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES + 1);
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    state_t        state_reg, state_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [W-1:0]  word_reg, word_next;
    logic [CW-1:0] hit_cnt_reg, hit_cnt_next;
    logic [IW-1:0] first_idx_reg, first_idx_next;

    logic [3:0]    nib_arr [NIBBLES];
    logic [3:0]    cur_nib;
    logic          nib_hit;

    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        assign nib_arr[gi] = word_reg[4*gi +: 4];
    end

    assign cur_nib = nib_arr[idx_reg];

    run3_nib u_nib (
        .nib (cur_nib),
        .hit (nib_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            word_reg      <= '0;
            hit_cnt_reg   <= '0;
            first_idx_reg <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            word_reg      <= word_next;
            hit_cnt_reg   <= hit_cnt_next;
            first_idx_reg <= first_idx_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        word_next      = word_reg;
        hit_cnt_next   = hit_cnt_reg;
        first_idx_next = first_idx_reg;
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        busy           = 1'b0;

        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    word_next      = in_data;
                    idx_next       = '0;
                    hit_cnt_next   = '0;
                    first_idx_next = '0;
                    state_next     = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (nib_hit) begin
                    hit_cnt_next = hit_cnt_reg + CW'(1);
                    // An empty count means this is the word's first hit.
                    if (hit_cnt_reg == '0) begin
                        first_idx_next = idx_reg;
                    end
                end
                if (idx_reg == LAST_IDX) begin
                    idx_next   = '0;
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg + IW'(1);
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign hit_cnt   = hit_cnt_reg;
    assign hit_any   = (hit_cnt_reg != '0);
    assign first_idx = first_idx_reg;

endmodule

// File: doc/run3_scan_ctrl.md
RUN3_SCAN_CTRL -- requirements
Module: run3_scan_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit nibbles per input word (minimum 2).
REQ-002 SHALL have input clk, 1 bit: the only clock; all state updates on rising edge.
REQ-003 SHALL have input rst_n, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have input in_valid, 1 bit: word offered.
REQ-005 SHALL have output in_ready, 1 bit: block accepts a word.
REQ-006 SHALL have input in_data, 4*NIBBLES bits: word to scan; nibble n is bits [4n+3:4n].
REQ-007 SHALL have output out_valid, 1 bit: result available.
REQ-008 SHALL have input out_ready, 1 bit: consumer takes the result.
REQ-009 SHALL have output hit_cnt, $clog2(NIBBLES+1) bits: number of nibbles containing a run of 3 or more equal adjacent bits.
REQ-010 SHALL have output hit_any, 1 bit: hit_cnt != 0.
REQ-011 SHALL have output first_idx, $clog2(NIBBLES) bits: lowest nibble index with a hit; 0 when no hit.
REQ-012 SHALL have output busy, 1 bit: high in SCAN or DONE.

Function
REQ-013 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE; never both high.
REQ-015 SHALL accept a word on an edge with in_valid && in_ready: latch in_data, clear idx, hit_cnt, first_idx, enter SCAN.
REQ-016 SHALL, in SCAN, evaluate exactly one nibble per cycle, in order idx=0..NIBBLES-1.
REQ-017 SHALL define a nibble hit as bits b0=b1=b2 or b1=b2=b3 within that nibble; a 4-bit run counts once.
REQ-018 SHALL ignore runs crossing nibble boundaries.
REQ-019 SHALL, on a hit, increment hit_cnt, and set first_idx=idx if it is the first hit of the word.
REQ-020 SHALL enter DONE on the edge that processes nibble NIBBLES-1; out_valid rises exactly NIBBLES cycles after the accepting edge.
REQ-021 SHALL hold hit_cnt, hit_any and first_idx stable while out_valid=1, whatever out_ready is.
REQ-022 SHALL return to IDLE on an edge with out_valid && out_ready; the next word is accepted no earlier than the following edge.
REQ-023 SHALL ignore in_valid and in_data in SCAN and DONE; the latched word is not overwritten.
REQ-024 SHALL keep hit_cnt saturation-free; its width holds NIBBLES exactly.

Reset
REQ-025 SHALL, while rst_n=0, force state IDLE, idx=0, hit_cnt=0, hit_any=0, first_idx=0, out_valid=0, busy=0, in_ready=1, regardless of clk.
REQ-026 SHALL discard any word in SCAN or DONE when reset is asserted; no result is produced for it.

Structure
REQ-027 SHALL place the state enum type (IDLE/SCAN/DONE) and the default NIBBLES constant in shared package run3_pkg.
REQ-028 SHALL instantiate one combinational sub-module run3_nib (4-bit in, 1-bit hit out) on the nibble selected by idx.

Verification (NIBBLES=4)
REQ-029 SHALL check in_data=16'h0000: hit_cnt=4, hit_any=1, first_idx=0, out_valid 4 cycles after accept.
REQ-030 SHALL check in_data=16'hA5A5: hit_cnt=0, hit_any=0, first_idx=0.
REQ-031 SHALL check in_data=16'h5E5A: hit_cnt=1, first_idx=2.
REQ-032 SHALL check in_data=16'h5AC3 (run spanning nibbles 0/1 only): hit_cnt=0, hit_any=0.
REQ-033 SHALL check backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and in_data=16'h0000 -> results unchanged, in_ready=0; after the handshake the new word is accepted in IDLE.
REQ-034 SHALL check rst_n low for 1 cycle in SCAN after nibble 1 -> all outputs at reset values immediately, in_ready=1, no out_valid for the aborted word.
